// File: rtl/kmeans_pkg.sv
// Shared constants and state encoding for the k-means centroid update stage.
package kmeans_pkg;

  localparam int unsigned centroid_num     = 8;
  localparam int unsigned dim              = 7;
  localparam int unsigned accum_cord_width = 22;
  localparam int unsigned cordinate_width  = 13;
  localparam int unsigned count_width      = 10;

  localparam int unsigned COORD_MAX = 8191;

  typedef logic [2:0] div_state_t;

  localparam div_state_t ST_IDLE  = 3'd0;
  localparam div_state_t ST_CHECK = 3'd1;
  localparam div_state_t ST_LOAD  = 3'd2;
  localparam div_state_t ST_DIV   = 3'd3;
  localparam div_state_t ST_STORE = 3'd4;
  localparam div_state_t ST_WRITE = 3'd5;
  localparam div_state_t ST_DONE  = 3'd6;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
module serial_divider
  import kmeans_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [accum_cord_width-1:0] dividend,
  input  logic [count_width-1:0]      divisor,
  output logic [accum_cord_width-1:0] quotient,
  output logic                        valid
);

  localparam int unsigned iter_w = $clog2(accum_cord_width + 1);

  logic [count_width-1:0] rem;
  logic [count_width-1:0] dvs;
  logic [iter_w-1:0]      iter;
  logic [count_width:0]   rem_sh;
  logic                   take;

  // The quotient register starts out holding the dividend; its MSB feeds the
  // remainder while quotient bits shift in at the LSB.
  always_comb begin
    rem_sh = {rem, quotient[accum_cord_width-1]};
    take   = (rem_sh >= {1'b0, dvs});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
      iter     <= '0;
    end else if (load) begin
      rem      <= '0;
      dvs      <= divisor;
      quotient <= dividend;
      iter     <= iter_w'(accum_cord_width);
    end else if (iter != '0) begin
      rem      <= take ? count_width'(rem_sh - {1'b0, dvs}) : rem_sh[count_width-1:0];
      quotient <= {quotient[accum_cord_width-2:0], take};
      iter     <= iter - iter_w'(1);
    end
  end

  // High during the final iteration; the quotient is complete from the next cycle.
  assign valid = (iter == iter_w'(1));

endmodule

// File: rtl/centroid_update_divider.sv
// Divides per-centroid coordinate sums by point counts and writes the new
// centroids to the centroid memory; empty centroids are left untouched.
module centroid_update_divider #(
  parameter int centroid_num     = 8,
  parameter int dim              = 7,
  parameter int accum_cord_width = 22,
  parameter int cordinate_width  = 13,
  parameter int count_width      = 10,
  parameter int dataWidth        = 91
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [dim*accum_cord_width-1:0]   accum_reg_1,
  input  logic [dim*accum_cord_width-1:0]   accum_reg_2,
  input  logic [dim*accum_cord_width-1:0]   accum_reg_3,
  input  logic [dim*accum_cord_width-1:0]   accum_reg_4,
  input  logic [dim*accum_cord_width-1:0]   accum_reg_5,
  input  logic [dim*accum_cord_width-1:0]   accum_reg_6,
  input  logic [dim*accum_cord_width-1:0]   accum_reg_7,
  input  logic [dim*accum_cord_width-1:0]   accum_reg_8,
  input  logic [count_width-1:0]            cnt_reg_1,
  input  logic [count_width-1:0]            cnt_reg_2,
  input  logic [count_width-1:0]            cnt_reg_3,
  input  logic [count_width-1:0]            cnt_reg_4,
  input  logic [count_width-1:0]            cnt_reg_5,
  input  logic [count_width-1:0]            cnt_reg_6,
  input  logic [count_width-1:0]            cnt_reg_7,
  input  logic [count_width-1:0]            cnt_reg_8,
  output logic                              busy,
  output logic                              done,
  output logic                              cent_wr_en,
  output logic [$clog2(centroid_num)-1:0]   cent_addr,
  output logic [dataWidth-1:0]              cent_data,
  output logic                              sat_flag
);

  import kmeans_pkg::*;

  localparam int k_w = $clog2(centroid_num);
  localparam int j_w = $clog2(dim);
  localparam logic [k_w-1:0] k_last = k_w'(centroid_num - 1);
  localparam logic [j_w-1:0] j_last = j_w'(dim - 1);

  logic [dim*accum_cord_width-1:0] accum [centroid_num];
  logic [count_width-1:0]          cnt   [centroid_num];

  assign accum[0] = accum_reg_1;
  assign accum[1] = accum_reg_2;
  assign accum[2] = accum_reg_3;
  assign accum[3] = accum_reg_4;
  assign accum[4] = accum_reg_5;
  assign accum[5] = accum_reg_6;
  assign accum[6] = accum_reg_7;
  assign accum[7] = accum_reg_8;
  assign cnt[0]   = cnt_reg_1;
  assign cnt[1]   = cnt_reg_2;
  assign cnt[2]   = cnt_reg_3;
  assign cnt[3]   = cnt_reg_4;
  assign cnt[4]   = cnt_reg_5;
  assign cnt[5]   = cnt_reg_6;
  assign cnt[6]   = cnt_reg_7;
  assign cnt[7]   = cnt_reg_8;

  div_state_t                      state;
  div_state_t                      state_next;
  logic [k_w-1:0]                  k;
  logic [j_w-1:0]                  j;
  logic [dataWidth-1:0]            res;
  logic [dataWidth-1:0]            res_next;
  logic [dim*accum_cord_width-1:0] cur_accum;
  logic [count_width-1:0]          cur_cnt;
  logic [accum_cord_width-1:0]     dividend;
  logic [accum_cord_width-1:0]     quotient;
  logic                            div_valid;
  logic                            sat_now;
  logic [cordinate_width-1:0]      coord;

  always_comb begin
    cur_accum = accum[k];
    cur_cnt   = cnt[k];
    dividend  = cur_accum[int'(j)*accum_cord_width +: accum_cord_width];
  end

  serial_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_LOAD),
    .dividend (dividend),
    .divisor  (cur_cnt),
    .quotient (quotient),
    .valid    (div_valid)
  );

  always_comb begin
    sat_now  = (quotient > accum_cord_width'(COORD_MAX));
    coord    = sat_now ? cordinate_width'(COORD_MAX) : quotient[cordinate_width-1:0];
    res_next = res;
    res_next[int'(j)*cordinate_width +: cordinate_width] = coord;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_CHECK;
      ST_CHECK: begin
        if (cur_cnt != '0)    state_next = ST_LOAD;
        else if (k == k_last) state_next = ST_DONE;
      end
      ST_LOAD:  state_next = ST_DIV;
      ST_DIV:   if (div_valid) state_next = ST_STORE;
      ST_STORE: state_next = (j == j_last) ? ST_WRITE : ST_LOAD;
      ST_WRITE: state_next = (k == k_last) ? ST_DONE : ST_CHECK;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // Outputs are registered from the next state so that the write strobe, address
  // and data appear together in the WRITE cycle and done in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      k          <= '0;
      j          <= '0;
      res        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cent_wr_en <= 1'b0;
      cent_addr  <= '0;
      cent_data  <= '0;
      sat_flag   <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != ST_IDLE) && (state_next != ST_DONE);
      done       <= (state_next == ST_DONE);
      cent_wr_en <= (state_next == ST_WRITE);
      if (state_next == ST_WRITE) begin
        cent_addr <= k;
        cent_data <= res_next;
      end
      if (!abort) begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              k        <= '0;
              sat_flag <= 1'b0;
            end
          end
          ST_CHECK: begin
            if (cur_cnt != '0)    j <= '0;
            else if (k != k_last) k <= k + k_w'(1);
          end
          ST_STORE: begin
            res <= res_next;
            if (sat_now)     sat_flag <= 1'b1;
            if (j != j_last) j <= j + j_w'(1);
          end
          ST_WRITE: if (k != k_last) k <= k + k_w'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_centroid_update_divider.sv
// Randomised bench for centroid_update_divider with a cycle-level schedule model.
module tb_centroid_update_divider;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [153:0] acc [8];
  logic [9:0]   cnt [8];
  logic [21:0]  sums [8][7];
  logic         busy, done, cent_wr_en, sat_flag;
  logic [2:0]   cent_addr;
  logic [90:0]  cent_data;

  int checks = 0;
  int errors = 0;

  // model / observation state
  int          mode = 0;   // 0 unchecked, 1 idle expected, 2 tracking a pass
  int          cyc;
  int          done_cyc;
  int          abort_edge;
  int          wr_cyc [8];
  logic [90:0] exp_data [8];
  logic        exp_sat;
  int          obs_done;
  int          obs_wr;
  logic [90:0] obs_data [8];
  logic        e_wr, e_busy, e_done, live;
  int          ek;

  always #5 clk = ~clk;

  centroid_update_divider dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .accum_reg_1(acc[0]), .accum_reg_2(acc[1]), .accum_reg_3(acc[2]), .accum_reg_4(acc[3]),
    .accum_reg_5(acc[4]), .accum_reg_6(acc[5]), .accum_reg_7(acc[6]), .accum_reg_8(acc[7]),
    .cnt_reg_1(cnt[0]), .cnt_reg_2(cnt[1]), .cnt_reg_3(cnt[2]), .cnt_reg_4(cnt[3]),
    .cnt_reg_5(cnt[4]), .cnt_reg_6(cnt[5]), .cnt_reg_7(cnt[6]), .cnt_reg_8(cnt[7]),
    .busy(busy), .done(done), .cent_wr_en(cent_wr_en), .cent_addr(cent_addr),
    .cent_data(cent_data), .sat_flag(sat_flag)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pack_inputs();
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 7; j++)
        acc[k][22*j +: 22] = sums[k][j];
  endtask

  task automatic fill(input int c, input int s);
    for (int k = 0; k < 8; k++) begin
      cnt[k] = 10'(c);
      for (int j = 0; j < 7; j++) sums[k][j] = 22'(s);
    end
  endtask

  // Expected schedule: empty centroid costs 1 cycle, non-empty 170 with its
  // write in the last of them; done follows the final centroid.
  task automatic plan();
    int t;
    int unsigned q;
    t = 1;
    exp_sat = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wr_cyc[k]   = -1;
      exp_data[k] = '0;
      if (cnt[k] == 0) begin
        t += 1;
      end else begin
        for (int j = 0; j < 7; j++) begin
          q = int'(sums[k][j]) / int'(cnt[k]);
          if (q > 8191) begin
            q = 8191;
            exp_sat = 1'b1;
          end
          exp_data[k][13*j +: 13] = q[12:0];
        end
        wr_cyc[k] = t + 169;
        t += 170;
      end
    end
    done_cyc = t;
  endtask

  always @(negedge clk) begin
    if (mode == 1) begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_wr", cent_wr_en, 0);
    end else if (mode == 2) begin
      cyc++;
      if (cyc >= 1) begin
        live   = (abort_edge < 0) || (cyc <= abort_edge);
        e_done = live && (cyc == done_cyc);
        e_busy = live && (cyc < done_cyc);
        e_wr   = 1'b0;
        ek     = 0;
        for (int k = 0; k < 8; k++)
          if (live && wr_cyc[k] == cyc) begin
            e_wr = 1'b1;
            ek   = k;
          end
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("wr_en", cent_wr_en, e_wr);
        if (e_wr) begin
          chk("addr", cent_addr, ek);
          chk("data", cent_data, exp_data[ek]);
        end
        if (cyc == 1) chk("sat_clear", sat_flag, 0);
        if (e_done)   chk("sat_end", sat_flag, exp_sat);
        if (cent_wr_en) begin
          obs_wr++;
          obs_data[cent_addr] = cent_data;
        end
        if (done) obs_done = cyc;
        if (cyc >= ((abort_edge < 0) ? done_cyc : abort_edge + 1)) mode = 1;
      end
    end
  end

  task automatic run_pass(input int abort_at, input int mid_start, input int rst_at);
    int n;
    plan();
    abort_edge = abort_at;
    obs_wr = 0;
    obs_done = -1;
    for (int k = 0; k < 8; k++) obs_data[k] = '0;
    start = 1'b1;
    cyc = -1;
    mode = 2;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (mode == 2 && n < 3000) begin
      if (n == rst_at) begin
        mode = 0;
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr", cent_wr_en, 0);
        chk("rst_addr", cent_addr, 0);
        chk("rst_data", cent_data, 0);
        chk("rst_sat", sat_flag, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mode = 1;
        repeat (400) @(posedge clk);
        #1;
        break;
      end
      if (n == abort_at)  abort = 1'b1;
      if (n == mid_start) start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      n++;
    end
    chk("pass_end", mode, 1);
    mode = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    fill(0, 0);
    pack_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wr", cent_wr_en, 0);
    chk("reset_addr", cent_addr, 0);
    chk("reset_data", cent_data, 0);
    chk("reset_sat", sat_flag, 0);
    rst = 1'b0;
    mode = 1;
    @(posedge clk); #1;

    // every centroid full: 100/10
    fill(10, 100);
    pack_inputs();
    run_pass(-1, -1, -1);
    chk("full_done_cyc", obs_done, 1361);
    chk("full_writes", obs_wr, 8);
    chk("full_data0", obs_data[0], {7{13'd10}});
    chk("full_data7", obs_data[7], {7{13'd10}});
    chk("full_sat", sat_flag, 0);

    // centroid 2 empty: 4095/4
    fill(4, 4095);
    cnt[2] = '0;
    pack_inputs();
    run_pass(-1, -1, -1);
    chk("skip_done_cyc", obs_done, 1192);
    chk("skip_writes", obs_wr, 7);
    chk("skip_data1", obs_data[1], {7{13'd1023}});
    chk("skip_data2", obs_data[2], 0);

    // saturation on centroid 0 coordinate 0
    fill(0, 5);
    cnt[0] = 10'd1;
    sums[0][0] = 22'd4194303;
    pack_inputs();
    run_pass(-1, -1, -1);
    chk("sat_done_cyc", obs_done, 178);
    chk("sat_data0", obs_data[0], {{6{13'd5}}, 13'd8191});
    chk("sat_after", sat_flag, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("sat_sticky", sat_flag, 1);

    // truncation and largest divisor
    fill(0, 0);
    cnt[0] = 10'd7;
    cnt[7] = 10'd1023;
    for (int j = 0; j < 7; j++) begin
      sums[0][j] = 22'd20;
      sums[7][j] = 22'd1023;
    end
    pack_inputs();
    run_pass(-1, -1, -1);
    chk("trunc_data0", obs_data[0], {7{13'd2}});
    chk("max_div_data7", obs_data[7], {7{13'd1}});
    chk("trunc_done_cyc", obs_done, 347);

    // all empty
    fill(0, 77);
    pack_inputs();
    run_pass(-1, -1, -1);
    chk("empty_done_cyc", obs_done, 9);
    chk("empty_writes", obs_wr, 0);

    // abort at cycle 200, then a normal pass
    fill(3, 999);
    pack_inputs();
    run_pass(200, -1, -1);
    chk("abort_no_done", obs_done, -1);
    chk("abort_writes", obs_wr, 1);
    run_pass(-1, -1, -1);
    chk("after_abort_writes", obs_wr, 8);

    // start while busy is ignored
    run_pass(-1, 500, -1);
    chk("midstart_done_cyc", obs_done, 1361);

    // reset during a divide
    run_pass(-1, -1, 30);
    chk("rst_no_writes", obs_wr, 0);

    // randomised passes
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0)      cnt[k] = '0;
        else if ($urandom_range(0, 2) == 0) cnt[k] = 10'($urandom_range(1, 3));
        else                                cnt[k] = 10'($urandom_range(1, 1023));
        for (int j = 0; j < 7; j++) sums[k][j] = 22'($urandom_range(0, 4194303));
      end
      pack_inputs();
      run_pass(-1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
